datamem_arbiter: RTL and testbench
==================================

DATAMEM_ARBITER -- requirements
Module: datamem_arbiter

Interface
REQ-001 Parameter DATAMEM_DEPTH, default 8192, data BRAM depth in 32-bit words; AW = $clog2(DATAMEM_DEPTH).
REQ-002 Parameter STARVE_LIMIT, default 4, range 1..15; max consecutive cycles port 1 waits while port 0 wins.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rstf  input  1  reset, asynchronous, active-low.
REQ-005 p0_valid / p1_valid  input  1  request valid; p0 = CPU dBus, p1 = loader/debug.
REQ-006 p0_ready / p1_ready  output  1  request accepted this cycle.
REQ-007 pN_addr  input  AW  word address; pN_wdata  input  32; pN_mask  input  4  byte enables; pN_we  input  1  1 = write.
REQ-008 pN_rsp_valid  output  1  read data valid; pN_rsp_data  output  32  read data.
REQ-009 mem_en  output  1; mem_we  output  1; mem_addr  output  AW; mem_wdata  output  32; mem_mask  output  4.
REQ-010 mem_ready  input  1  BRAM accepts the command this cycle; mem_rdata  input  32  valid exactly 1 cycle after accepted read.
REQ-011 starve_force  output  1  status: port 1 force-granted this cycle.

Function
REQ-012 Grant is combinational: winner drives mem_addr/wdata/mask/we; mem_en = p0_valid | p1_valid.
REQ-013 Default priority: port 0 wins when both valid.
REQ-014 wait_cnt (4 bit) increments each cycle p1_valid=1 and p1 not accepted; clears when p1 accepted or p1_valid=0; saturates at STARVE_LIMIT.
REQ-015 When wait_cnt == STARVE_LIMIT, port 1 wins regardless of p0_valid; starve_force=1 that cycle.
REQ-016 pN_ready = winner==N & mem_ready; a transfer completes when pN_valid & pN_ready.
REQ-017 Loser's ready = 0; requesters hold valid and payload stable until ready.
REQ-018 No grant or wait_cnt change is visible to mem while mem_ready=0; wait_cnt still counts stalled p1 cycles.
REQ-019 Accepted read registers rd_pending=1 and rd_owner=N; next cycle pN_rsp_valid=1, pN_rsp_data=mem_rdata; other port rsp_valid=0.
REQ-020 Read latency fixed at 1 cycle; back-to-back reads allowed every cycle, alternating owners allowed.
REQ-021 Writes produce no response; write followed by read of same address on next cycle returns new data (BRAM write-first is not required; ordering is by acceptance).
REQ-022 Responses are not stallable; requesters must sink rsp_valid.
REQ-023 pN_rsp_data = 0 when pN_rsp_valid = 0.
REQ-024 Neither valid: mem_en=0, both ready=0, wait_cnt cleared.

Reset
REQ-025 rstf low: wait_cnt=0, rd_pending=0, rd_owner=0 immediately (asynchronous).
REQ-026 During reset all outputs 0: pN_ready, pN_rsp_valid, pN_rsp_data, mem_en, mem_we, starve_force; mem_addr/wdata/mask = 0.
REQ-027 Read accepted the cycle before reset assertion produces no response after release.
REQ-028 First grant possible in first cycle after rstf deasserts.

Structure
REQ-029 Shared package dmem_pkg: DATAMEM_DEPTH default, port-index enum {PORT_CPU, PORT_LOAD}, request struct {addr, wdata, mask, we}.
REQ-030 One sub-module dmem_starve_ctr: wait_cnt with inc/clear/saturate, output at_limit.
REQ-031 Sits between databus_demux datamem port and BRAM; datamem_ready maps to p0_ready.

Verification
REQ-032 Both valid reads, mem_ready=1, addr p0=0x10 p1=0x20 -> p0 granted cycles 0-3, p1 granted cycle 4 (STARVE_LIMIT=4), starve_force=1 cycle 4.
REQ-033 p0 write 0xDEADBEEF mask 0xF addr 0x5, then p1 read addr 0x5 -> p1_rsp_valid next cycle, data 0xDEADBEEF, p0_rsp_valid=0.
REQ-034 Alternating reads p0/p1 every cycle -> rsp_valid routed to correct port each cycle, no lost or duplicated response.
REQ-035 mem_ready=0 for 3 cycles with p1 pending -> no ready, payload stable, p1 granted once mem_ready=1 and wait_cnt reached limit.
REQ-036 rstf asserted one cycle after accepted read -> no rsp_valid after release, wait_cnt=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and sizing for the data-memory arbiter.
// Provides the default BRAM depth, the requester port index and the request
// payload struct used to mux the winning port onto the BRAM command bus.
package dmem_pkg;

    localparam int unsigned DATAMEM_DEPTH_DEFAULT = 8192;
    localparam int unsigned ADDR_W_MAX            = 32;
    localparam int unsigned DATA_W                = 32;
    localparam int unsigned MASK_W                = 4;
    localparam int unsigned CNT_W                 = 4;

    typedef enum logic {
        PORT_CPU  = 1'b0,
        PORT_LOAD = 1'b1
    } port_e;

    // Address is carried at maximum width; users zero-extend and truncate to AW.
    typedef struct packed {
        logic [ADDR_W_MAX-1:0] addr;
        logic [DATA_W-1:0]     wdata;
        logic [MASK_W-1:0]     mask;
        logic                  we;
    } dmem_req_t;

endpackage

// File: rtl/datamem_arbiter_if.sv
// Bus bundle around the data-memory arbiter.
// p0 = CPU dBus, p1 = loader/debug, mem_* = BRAM command/response.
// slave  : arbiter view (takes requests, drives BRAM command).
// master : environment view (requesters and BRAM).
interface datamem_arbiter_if #(
    parameter int unsigned AW = 13
);

    logic                        p0_valid;
    logic                        p0_ready;
    logic [AW-1:0]               p0_addr;
    logic [dmem_pkg::DATA_W-1:0] p0_wdata;
    logic [dmem_pkg::MASK_W-1:0] p0_mask;
    logic                        p0_we;
    logic                        p0_rsp_valid;
    logic [dmem_pkg::DATA_W-1:0] p0_rsp_data;

    logic                        p1_valid;
    logic                        p1_ready;
    logic [AW-1:0]               p1_addr;
    logic [dmem_pkg::DATA_W-1:0] p1_wdata;
    logic [dmem_pkg::MASK_W-1:0] p1_mask;
    logic                        p1_we;
    logic                        p1_rsp_valid;
    logic [dmem_pkg::DATA_W-1:0] p1_rsp_data;

    logic                        mem_en;
    logic                        mem_we;
    logic [AW-1:0]               mem_addr;
    logic [dmem_pkg::DATA_W-1:0] mem_wdata;
    logic [dmem_pkg::MASK_W-1:0] mem_mask;
    logic                        mem_ready;
    logic [dmem_pkg::DATA_W-1:0] mem_rdata;

    modport slave (
        input  p0_valid, p0_addr, p0_wdata, p0_mask, p0_we,
        input  p1_valid, p1_addr, p1_wdata, p1_mask, p1_we,
        input  mem_ready, mem_rdata,
        output p0_ready, p0_rsp_valid, p0_rsp_data,
        output p1_ready, p1_rsp_valid, p1_rsp_data,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_mask
    );

    modport master (
        output p0_valid, p0_addr, p0_wdata, p0_mask, p0_we,
        output p1_valid, p1_addr, p1_wdata, p1_mask, p1_we,
        output mem_ready, mem_rdata,
        input  p0_ready, p0_rsp_valid, p0_rsp_data,
        input  p1_ready, p1_rsp_valid, p1_rsp_data,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_mask
    );

endinterface

// File: rtl/dmem_starve_ctr.sv
// Port-1 starvation counter.
// Counts cycles port 1 waits, clears on clr_i, saturates at LIMIT.
// Ports: clk, rstf (async active-low), inc_i, clr_i (priority over inc_i),
//        at_limit_o (counter equals LIMIT).
module dmem_starve_ctr
    import dmem_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rstf,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign at_limit_o = (cnt_q == CNT_W'(LIMIT));

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_limit_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/datamem_arbiter.sv
// Two-port arbiter in front of the data BRAM.
// Port 0 (CPU) has priority; port 1 (loader/debug) is force-granted after
// waiting STARVE_LIMIT cycles. Grant is combinational; reads return one
// cycle after acceptance on the owning port.
// Ports: clk, rstf (async active-low), bus (datamem_arbiter_if.slave),
//        starve_force (port 1 force-granted this cycle).
module datamem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DATAMEM_DEPTH = DATAMEM_DEPTH_DEFAULT,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic              clk,
    input  logic              rstf,
    datamem_arbiter_if.slave  bus,
    output logic              starve_force
);

    localparam int unsigned AW = $clog2(DATAMEM_DEPTH);

    dmem_req_t req0;
    dmem_req_t req1;
    dmem_req_t sel;
    port_e     winner;
    logic      at_limit;
    logic      force_c;
    logic      mem_en_c;
    logic      p0_ready_c;
    logic      p1_ready_c;
    logic      p1_wait_c;
    logic      rd_accept_c;
    logic      rd_pending_q;
    logic      rd_pending_d;
    port_e     rd_owner_q;
    port_e     rd_owner_d;
    logic      unused_addr_hi;

    // Winner selection and payload mux.
    always_comb begin
        req0    = '{addr: ADDR_W_MAX'(bus.p0_addr), wdata: bus.p0_wdata,
                    mask: bus.p0_mask, we: bus.p0_we};
        req1    = '{addr: ADDR_W_MAX'(bus.p1_addr), wdata: bus.p1_wdata,
                    mask: bus.p1_mask, we: bus.p1_we};
        force_c = at_limit && bus.p1_valid;
        winner  = PORT_CPU;
        if (force_c || (bus.p1_valid && !bus.p0_valid)) begin
            winner = PORT_LOAD;
        end
        sel = (winner == PORT_LOAD) ? req1 : req0;
    end

    // Everything visible to the BRAM or requesters is held at 0 in reset.
    assign mem_en_c      = rstf && (bus.p0_valid || bus.p1_valid);
    assign p0_ready_c    = rstf && bus.p0_valid && (winner == PORT_CPU)  && bus.mem_ready;
    assign p1_ready_c    = rstf && bus.p1_valid && (winner == PORT_LOAD) && bus.mem_ready;
    assign p1_wait_c     = bus.p1_valid && !p1_ready_c;
    assign rd_accept_c   = mem_en_c && bus.mem_ready && !sel.we;

    assign bus.p0_ready  = p0_ready_c;
    assign bus.p1_ready  = p1_ready_c;
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_en_c && sel.we;
    assign bus.mem_addr  = rstf ? AW'(sel.addr) : '0;
    assign bus.mem_wdata = rstf ? sel.wdata : '0;
    assign bus.mem_mask  = rstf ? sel.mask : '0;
    assign starve_force  = rstf && force_c;

    assign unused_addr_hi = ^sel.addr[ADDR_W_MAX-1:AW];

    dmem_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rstf       (rstf),
        .inc_i      (p1_wait_c),
        .clr_i      (!p1_wait_c),
        .at_limit_o (at_limit)
    );

    // Read tracking: one-cycle response owned by the accepting port.
    always_comb begin
        rd_pending_d = rd_accept_c;
        rd_owner_d   = rd_owner_q;
        if (rd_accept_c) begin
            rd_owner_d = winner;
        end
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            rd_pending_q <= 1'b0;
            rd_owner_q   <= PORT_CPU;
        end else begin
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    assign bus.p0_rsp_valid = rd_pending_q && (rd_owner_q == PORT_CPU);
    assign bus.p1_rsp_valid = rd_pending_q && (rd_owner_q == PORT_LOAD);
    assign bus.p0_rsp_data  = bus.p0_rsp_valid ? bus.mem_rdata : '0;
    assign bus.p1_rsp_data  = bus.p1_rsp_valid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Self-checking bench for datamem_arbiter: directed scenarios plus a
// randomized phase, checked against a behavioural model of the arbitration
// rules and a reference memory image.
module tb_datamem_arbiter;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rstf;
    logic        starve_force;
    int unsigned total = 0;
    int unsigned bad   = 0;

    datamem_arbiter_if #(.AW(AW)) bus ();

    datamem_arbiter #(
        .DATAMEM_DEPTH (DEPTH),
        .STARVE_LIMIT  (LIMIT)
    ) dut (
        .clk          (clk),
        .rstf         (rstf),
        .bus          (bus),
        .starve_force (starve_force)
    );

    always #5 clk = ~clk;

    // BRAM behaviour: 1-cycle read latency, byte-masked writes.
    logic [31:0] bram [DEPTH];
    logic [31:0] rdata_q;
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_ready) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_mask[b]) bram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end else begin
                rdata_q <= bram[bus.mem_addr];
            end
        end
    end
    assign bus.mem_rdata = rdata_q;

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    int unsigned w = 0;            // cycles port 1 has been kept waiting
    logic        exp_pend = 1'b0;  // a read response is due this cycle
    logic        exp_owner = 1'b0; // 0 = port 0, 1 = port 1
    logic [31:0] exp_data = '0;
    logic        acc0 = 1'b0, acc1 = 1'b0;
    logic [31:0] obs_p0_rv, obs_p1_rv, obs_p1_ready, obs_force, obs_p1_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int port, input logic v, input logic [AW-1:0] a,
                         input logic we, input logic [31:0] d, input logic [3:0] m);
        if (port == 0) begin
            bus.p0_valid = v; bus.p0_addr = a; bus.p0_we = we; bus.p0_wdata = d; bus.p0_mask = m;
        end else begin
            bus.p1_valid = v; bus.p1_addr = a; bus.p1_we = we; bus.p1_wdata = d; bus.p1_mask = m;
        end
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the model.
    task automatic cycle(input string tag);
        logic v0, v1, mr, frc, win1, r0, r1, we_w;
        logic [AW-1:0] a_w;
        logic [31:0]   d_w;
        logic [3:0]    m_w;
        @(negedge clk);
        v0   = bus.p0_valid;
        v1   = bus.p1_valid;
        mr   = bus.mem_ready;
        frc  = v1 && (w == LIMIT);
        win1 = frc || (v1 && !v0);
        r0   = v0 && !win1 && mr;
        r1   = v1 && win1 && mr;
        a_w  = win1 ? bus.p1_addr  : bus.p0_addr;
        we_w = win1 ? bus.p1_we    : bus.p0_we;
        d_w  = win1 ? bus.p1_wdata : bus.p0_wdata;
        m_w  = win1 ? bus.p1_mask  : bus.p0_mask;
        chk({tag, ":p0_ready"}, 32'(bus.p0_ready), 32'(r0));
        chk({tag, ":p1_ready"}, 32'(bus.p1_ready), 32'(r1));
        chk({tag, ":mem_en"}, 32'(bus.mem_en), 32'(v0 || v1));
        chk({tag, ":starve_force"}, 32'(starve_force), 32'(frc));
        if (v0 || v1) begin
            chk({tag, ":mem_addr"}, 32'(bus.mem_addr), 32'(a_w));
            chk({tag, ":mem_we"}, 32'(bus.mem_we), 32'(we_w));
            chk({tag, ":mem_wdata"}, bus.mem_wdata, d_w);
            chk({tag, ":mem_mask"}, 32'(bus.mem_mask), 32'(m_w));
        end
        chk({tag, ":p0_rsp_valid"}, 32'(bus.p0_rsp_valid), 32'(exp_pend && !exp_owner));
        chk({tag, ":p1_rsp_valid"}, 32'(bus.p1_rsp_valid), 32'(exp_pend && exp_owner));
        chk({tag, ":p0_rsp_data"}, bus.p0_rsp_data, (exp_pend && !exp_owner) ? exp_data : 32'h0);
        chk({tag, ":p1_rsp_data"}, bus.p1_rsp_data, (exp_pend && exp_owner) ? exp_data : 32'h0);
        obs_p0_rv    = 32'(bus.p0_rsp_valid);
        obs_p1_rv    = 32'(bus.p1_rsp_valid);
        obs_p1_ready = 32'(bus.p1_ready);
        obs_force    = 32'(starve_force);
        obs_p1_data  = bus.p1_rsp_data;
        // Model update: acceptance order defines memory contents and responses.
        exp_pend = 1'b0;
        if ((r0 || r1) && !we_w) begin
            exp_pend  = 1'b1;
            exp_owner = win1;
            exp_data  = ref_mem[a_w];
        end
        if ((r0 || r1) && we_w) begin
            for (int b = 0; b < 4; b++) begin
                if (m_w[b]) ref_mem[a_w][8*b +: 8] = d_w[8*b +: 8];
            end
        end
        w    = (v1 && !r1) ? ((w < LIMIT) ? w + 1 : LIMIT) : 0;
        acc0 = r0;
        acc1 = r1;
        @(posedge clk);
        #1;
    endtask

    // Assert reset and check every output is forced low.
    task automatic reset_check(input string tag);
        rstf = 1'b0;
        #1;
        chk({tag, ":p0_ready"}, 32'(bus.p0_ready), 0);
        chk({tag, ":p1_ready"}, 32'(bus.p1_ready), 0);
        chk({tag, ":p0_rsp_valid"}, 32'(bus.p0_rsp_valid), 0);
        chk({tag, ":p1_rsp_valid"}, 32'(bus.p1_rsp_valid), 0);
        chk({tag, ":p0_rsp_data"}, bus.p0_rsp_data, 0);
        chk({tag, ":p1_rsp_data"}, bus.p1_rsp_data, 0);
        chk({tag, ":mem_en"}, 32'(bus.mem_en), 0);
        chk({tag, ":mem_we"}, 32'(bus.mem_we), 0);
        chk({tag, ":mem_addr"}, 32'(bus.mem_addr), 0);
        chk({tag, ":mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, ":mem_mask"}, 32'(bus.mem_mask), 0);
        chk({tag, ":starve_force"}, 32'(starve_force), 0);
        w        = 0;
        exp_pend = 1'b0;
        acc0     = 1'b0;
        acc1     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bus.mem_ready = 1'b1;
        drive(0, 1'b1, AW'(3), 1'b1, 32'h1234_5678, 4'hF);
        drive(1, 1'b1, AW'(7), 1'b0, 32'h0, 4'hF);
        reset_check("rst0");
        drive(0, 1'b0, '0, 1'b0, 32'h0, 4'h0);
        drive(1, 1'b0, '0, 1'b0, 32'h0, 4'h0);
        rstf = 1'b1;

        // Preload through port 1; first write lands in the first cycle after reset.
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1, 1'b1, AW'(i), 1'b1, (32'(i) * 32'h0101_0101) ^ 32'hA5A5_A5A5, 4'hF);
            cycle("preload");
        end

        // Both ports read continuously: port 1 force-granted on the 5th cycle.
        drive(0, 1'b1, AW'(6'h10), 1'b0, 32'h0, 4'hF);
        drive(1, 1'b1, AW'(6'h20), 1'b0, 32'h0, 4'hF);
        for (int k = 0; k < 6; k++) begin
            cycle("starve");
            chk("starve_p1_ready", obs_p1_ready, 32'(k == 4));
            chk("starve_force_k", obs_force, 32'(k == 4));
            if (k == 4) drive(1, 1'b0, '0, 1'b0, 32'h0, 4'h0);
        end
        drive(0, 1'b0, '0, 1'b0, 32'h0, 4'h0);

        // Write on port 0, read back on port 1 the next cycle.
        drive(0, 1'b1, AW'(5), 1'b1, 32'hDEAD_BEEF, 4'hF);
        cycle("wr5");
        drive(0, 1'b0, '0, 1'b0, 32'h0, 4'h0);
        drive(1, 1'b1, AW'(5), 1'b0, 32'h0, 4'hF);
        cycle("rd5");
        drive(1, 1'b0, '0, 1'b0, 32'h0, 4'h0);
        cycle("rsp5");
        chk("rsp5_p1_valid", obs_p1_rv, 1);
        chk("rsp5_p1_data", obs_p1_data, 32'hDEAD_BEEF);
        chk("rsp5_p0_valid", obs_p0_rv, 0);

        // Alternating single-port reads every cycle.
        for (int k = 0; k < 10; k++) begin
            drive(k % 2, 1'b1, AW'(k + 8), 1'b0, 32'h0, 4'hF);
            drive(1 - (k % 2), 1'b0, '0, 1'b0, 32'h0, 4'h0);
            cycle("alt");
            chk("alt_p0_route", obs_p0_rv, 32'((k > 0) && ((k - 1) % 2 == 0)));
            chk("alt_p1_route", obs_p1_rv, 32'((k > 0) && ((k - 1) % 2 == 1)));
        end
        drive(1, 1'b0, '0, 1'b0, 32'h0, 4'h0);
        cycle("alt_tail");
        chk("alt_tail_p1", obs_p1_rv, 1);

        // BRAM stalls 3 cycles with both ports pending.
        drive(0, 1'b1, AW'(7), 1'b0, 32'h0, 4'hF);
        drive(1, 1'b1, AW'(9), 1'b0, 32'h0, 4'hF);
        bus.mem_ready = 1'b0;
        repeat (3) cycle("stall");
        bus.mem_ready = 1'b1;
        n = 0;
        obs_p1_ready = 0;
        while (n < 8 && obs_p1_ready == 0) begin
            cycle("stall_rel");
            n++;
        end
        chk("stall_rel_cycles", 32'(n), 2);
        drive(1, 1'b0, '0, 1'b0, 32'h0, 4'h0);

        // Long stall: counter saturates and force stays asserted.
        drive(1, 1'b1, AW'(11), 1'b0, 32'h0, 4'hF);
        bus.mem_ready = 1'b0;
        repeat (8) cycle("sat");
        chk("sat_force", obs_force, 1);
        bus.mem_ready = 1'b1;
        cycle("sat_rel");
        chk("sat_rel_p1_ready", obs_p1_ready, 1);
        drive(1, 1'b0, '0, 1'b0, 32'h0, 4'h0);
        drive(0, 1'b0, '0, 1'b0, 32'h0, 4'h0);
        cycle("idle");

        // Reset one cycle after an accepted read with port 1 waiting.
        drive(0, 1'b1, AW'(3), 1'b0, 32'h0, 4'hF);
        drive(1, 1'b1, AW'(4), 1'b0, 32'h0, 4'hF);
        repeat (2) cycle("pre_rst");
        reset_check("rst1");
        drive(0, 1'b0, '0, 1'b0, 32'h0, 4'h0);
        drive(1, 1'b0, '0, 1'b0, 32'h0, 4'h0);
        rstf = 1'b1;
        cycle("post_rst");
        chk("post_rst_p0_rsp", obs_p0_rv, 0);
        chk("post_rst_wait_cnt", 32'(dut.u_starve.cnt_q), 0);

        // Randomized traffic with hold-until-ready requesters.
        for (int k = 0; k < 400; k++) begin
            if (!bus.p0_valid || acc0) begin
                if ($urandom_range(0, 9) < 6)
                    drive(0, 1'b1, AW'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 3) == 0,
                          $urandom, 4'($urandom_range(1, 15)));
                else
                    drive(0, 1'b0, '0, 1'b0, 32'h0, 4'h0);
            end
            if (!bus.p1_valid || acc1) begin
                if ($urandom_range(0, 9) < 6)
                    drive(1, 1'b1, AW'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 3) == 0,
                          $urandom, 4'($urandom_range(1, 15)));
                else
                    drive(1, 1'b0, '0, 1'b0, 32'h0, 4'h0);
            end
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            cycle("rnd");
        end
        drive(0, 1'b0, '0, 1'b0, 32'h0, 4'h0);
        drive(1, 1'b0, '0, 1'b0, 32'h0, 4'h0);
        bus.mem_ready = 1'b1;
        cycle("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
